keccak_stream_ctrl: RTL and testbench
=====================================

# keccak_stream_ctrl

Parametrised lane-serial controller between a wide state register and a lane-serial Keccak core. It accepts a full state word on a start handshake and streams a programmable number of lanes into the core. It then signals the last block and collects a programmable number of output lanes back into a wide result register. A watchdog aborts the transaction if the core stops producing output.

## Interface

Parameters:
- STATE_W, 1600, width of the wide state/result registers.
- LANE_W, 64, width of one core lane; STATE_W must be an integer multiple of LANE_W.
- NUM_LANES, STATE_W/LANE_W (derived, 25 by default), lanes per state.
- TIMEOUT_CYCLES, 1024, maximum idle cycles allowed while waiting for output lanes (≥1).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  transaction request, sampled only in IDLE.
- din_i  in  STATE_W  input state; lane k = din_i[k*LANE_W +: LANE_W].
- in_lanes_i  in  $clog2(NUM_LANES+1)  lanes to absorb; 0 or >NUM_LANES means NUM_LANES.
- out_lanes_i  in  $clog2(NUM_LANES+1)  lanes to collect; same clamping rule.
- ready_keccak_i  in  1  core idle and able to start.
- dout_keccak_i  in  LANE_W  core output lane.
- dout_valid_keccak_i  in  1  core output lane valid.
- start_keccak_o  out  1  one-cycle core start pulse.
- din_keccak_o  out  LANE_W  lane to core; 0 when din_valid_keccak_o is low.
- din_valid_keccak_o  out  1  lane valid to core.
- last_block_keccak_o  out  1  one-cycle last-block pulse.
- dout_o  out  STATE_W  collected result; lanes ≥ out_lanes are 0.
- busy_o  out  1  transaction in progress.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  watchdog fired; sticky until the next accepted start.

## Operation

- States: IDLE, START, LOAD, LAST, COLLECT, DONE.
- IDLE, when start_i && ready_keccak_i: capture din_i into the shadow register. Latch the clamped in_lanes_i and out_lanes_i. Clear dout_o and error_o, set busy_o, and go to START.
- While busy_o is high, start_i is ignored.
- START: assert start_keccak_o for one cycle, then go to LOAD with lane index 0.
- LOAD: on each cycle, drive din_keccak_o from shadow lane[idx] and assert din_valid_keccak_o, then increment idx. After lane in_lanes-1 is driven, go to LAST.
- LAST: assert last_block_keccak_o for one cycle with din_valid_keccak_o low, then go to COLLECT with out index 0 and the watchdog cleared.
- COLLECT, on each cycle with dout_valid_keccak_i high: write dout_keccak_i to dout_o lane[oidx], increment oidx, and clear the watchdog. When the lane written is oidx = out_lanes-1, go to DONE.
- COLLECT, on each cycle without valid: increment the watchdog.
- COLLECT, when the watchdog reaches TIMEOUT_CYCLES: set error_o and go to DONE. Lanes collected so far are kept.
- DONE: pulse done_o, clear busy_o, and return to IDLE. dout_o and error_o hold until the next accepted start.
- dout_valid_keccak_i outside COLLECT is ignored.
- Output lanes beyond out_lanes are never written.
- Width rules:
  - Lane and output indices are $clog2(NUM_LANES+1) bits.
  - The watchdog is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - The shadow register is STATE_W bits.

## Timing

- Reset (rst_ni low at an edge):
  - State becomes IDLE.
  - All outputs are 0, including dout_o, error_o and busy_o.
  - The shadow register, indices and watchdog are cleared.
- Reset overrides everything mid-transaction; no done_o is generated.
- All outputs are registered.
- Cycle sequence, with the start accepted at edge E0:
  - Cycle after E0: start_keccak_o=1 and busy_o=1.
  - Next in_lanes cycles: one lane per cycle, lane 0 first.
  - Following cycle: last_block_keccak_o=1.
- For a valid lane sampled at edge Ek, the dout_o lane is updated after Ek.
- After the final lane: done_o=1 for the cycle after that edge, and busy_o falls at the same edge that ends DONE.
- Minimum latency from acceptance to done_o is in_lanes + out_lanes + 3 cycles, reached when the core returns one valid lane per cycle immediately after LAST.
- A new start can be accepted in the first IDLE cycle after DONE.
- start_i high with ready_keccak_i low: the controller stays in IDLE and produces no pulses.

## Test plan

- Default parameters, in/out lanes = 25, din_i lane k = k+1, core model echoing lanes with 5-cycle latency:
  - one start_keccak_o pulse, then 25 din_valid beats carrying 1..25, then last_block_keccak_o;
  - dout_o lane k = k+1 and one done_o pulse;
  - busy_o high for exactly 25+25+3+4 cycles of wait.
- in_lanes = 17, out_lanes = 4:
  - exactly 17 beats are driven;
  - dout_o lanes 0..3 hold the data and lanes 4..24 are 0;
  - in_lanes = 0 produces 25 beats.
- Core stops after 2 of 4 output lanes with TIMEOUT_CYCLES = 8:
  - error_o rises and done_o pulses 8 cycles after the last valid;
  - lanes 0..1 are kept;
  - the next start clears error_o.
- start_i held high with ready_keccak_i low for 10 cycles: no start_keccak_o. Raising ready starts the transaction on the next edge.
- start_i re-pulsed mid-LOAD: no effect.
- rst_ni low during COLLECT: all outputs 0 next cycle, no done_o, and a subsequent full transaction completes correctly.

Source files
------------

// File: rtl/keccak_stream_ctrl.sv
// Lane-serial bridge between a wide state register and a lane-serial Keccak core:
// streams input lanes in, pulses last-block, then collects output lanes under a watchdog.
module keccak_stream_ctrl #(
    parameter int unsigned STATE_W        = 1600,
    parameter int unsigned LANE_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned NUM_LANES     = STATE_W / LANE_W,
    localparam int unsigned IDX_W         = $clog2(NUM_LANES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [STATE_W-1:0] din_i,
    input  logic [IDX_W-1:0]   in_lanes_i,
    input  logic [IDX_W-1:0]   out_lanes_i,
    input  logic               ready_keccak_i,
    input  logic [LANE_W-1:0]  dout_keccak_i,
    input  logic               dout_valid_keccak_i,
    output logic               start_keccak_o,
    output logic [LANE_W-1:0]  din_keccak_o,
    output logic               din_valid_keccak_o,
    output logic               last_block_keccak_o,
    output logic [STATE_W-1:0] dout_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StLoad, StLast, StCollect, StDone
    } state_e;

    state_e             r_state, w_state_d;
    logic [STATE_W-1:0] r_shadow, w_shadow_d;
    logic [STATE_W-1:0] r_dout, w_dout_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;
    logic [IDX_W-1:0]   r_oidx, w_oidx_d;
    logic [IDX_W-1:0]   r_in_n, w_in_n_d;
    logic [IDX_W-1:0]   r_out_n, w_out_n_d;
    logic [WD_W-1:0]    r_wd, w_wd_d;
    logic               r_error, w_error_d;
    logic [LANE_W-1:0]  r_din_k, w_din_k_d;
    logic               r_start_k, r_din_valid, r_last, r_busy, r_done;

    // Zero or out-of-range lane counts mean "whole state".
    function automatic logic [IDX_W-1:0] clamp_lanes(input logic [IDX_W-1:0] n);
        if (n == '0 || n > IDX_W'(NUM_LANES)) begin
            return IDX_W'(NUM_LANES);
        end
        return n;
    endfunction

    always_comb begin
        w_state_d  = r_state;
        w_shadow_d = r_shadow;
        w_dout_d   = r_dout;
        w_idx_d    = r_idx;
        w_oidx_d   = r_oidx;
        w_in_n_d   = r_in_n;
        w_out_n_d  = r_out_n;
        w_wd_d     = r_wd;
        w_error_d  = r_error;
        w_din_k_d  = '0;

        unique case (r_state)
            StIdle: begin
                if (start_i && ready_keccak_i) begin
                    w_shadow_d = din_i;
                    w_in_n_d   = clamp_lanes(in_lanes_i);
                    w_out_n_d  = clamp_lanes(out_lanes_i);
                    w_dout_d   = '0;
                    w_error_d  = 1'b0;
                    w_state_d  = StStart;
                end
            end
            StStart: begin
                w_idx_d   = '0;
                w_state_d = StLoad;
            end
            StLoad: begin
                w_idx_d = r_idx + IDX_W'(1);
                if (r_idx == r_in_n - IDX_W'(1)) begin
                    w_state_d = StLast;
                end
            end
            StLast: begin
                w_oidx_d  = '0;
                w_wd_d    = '0;
                w_state_d = StCollect;
            end
            StCollect: begin
                if (dout_valid_keccak_i) begin
                    w_dout_d[int'(r_oidx)*LANE_W +: LANE_W] = dout_keccak_i;
                    w_oidx_d = r_oidx + IDX_W'(1);
                    w_wd_d   = '0;
                    if (r_oidx == r_out_n - IDX_W'(1)) begin
                        w_state_d = StDone;
                    end
                end else begin
                    if (r_wd != WD_W'(TIMEOUT_CYCLES)) begin
                        w_wd_d = r_wd + WD_W'(1);
                    end
                    if (w_wd_d == WD_W'(TIMEOUT_CYCLES)) begin
                        w_error_d = 1'b1;
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Lane for the next cycle is selected ahead so the core sees a registered value.
        if (w_state_d == StLoad) begin
            w_din_k_d = r_shadow[int'(w_idx_d)*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_shadow    <= '0;
            r_dout      <= '0;
            r_idx       <= '0;
            r_oidx      <= '0;
            r_in_n      <= '0;
            r_out_n     <= '0;
            r_wd        <= '0;
            r_error     <= 1'b0;
            r_din_k     <= '0;
            r_start_k   <= 1'b0;
            r_din_valid <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_shadow    <= w_shadow_d;
            r_dout      <= w_dout_d;
            r_idx       <= w_idx_d;
            r_oidx      <= w_oidx_d;
            r_in_n      <= w_in_n_d;
            r_out_n     <= w_out_n_d;
            r_wd        <= w_wd_d;
            r_error     <= w_error_d;
            r_din_k     <= w_din_k_d;
            r_start_k   <= (w_state_d == StStart);
            r_din_valid <= (w_state_d == StLoad);
            r_last      <= (w_state_d == StLast);
            r_busy      <= (w_state_d != StIdle);
            r_done      <= (w_state_d == StDone);
        end
    end

    assign start_keccak_o      = r_start_k;
    assign din_keccak_o        = r_din_k;
    assign din_valid_keccak_o  = r_din_valid;
    assign last_block_keccak_o = r_last;
    assign dout_o              = r_dout;
    assign busy_o              = r_busy;
    assign done_o              = r_done;
    assign error_o             = r_error;

endmodule

// File: tb/tb_keccak_stream_ctrl.sv
// Directed bench for keccak_stream_ctrl: an inline core model echoes absorbed lanes back
// after a programmable delay; each scenario task checks its own hand-computed expectations.
module tb_keccak_stream_ctrl;
    localparam int STATE_W = 1600;
    localparam int LANE_W  = 64;
    localparam int NL      = STATE_W / LANE_W;
    localparam int IDX_W   = $clog2(NL + 1);
    localparam int TIMEOUT = 8;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               start_i;
    logic [STATE_W-1:0] din_i;
    logic [IDX_W-1:0]   in_lanes_i;
    logic [IDX_W-1:0]   out_lanes_i;
    logic               ready_keccak_i;
    logic [LANE_W-1:0]  dout_keccak_i;
    logic               dout_valid_keccak_i;
    logic               start_keccak_o;
    logic [LANE_W-1:0]  din_keccak_o;
    logic               din_valid_keccak_o;
    logic               last_block_keccak_o;
    logic [STATE_W-1:0] dout_o;
    logic               busy_o;
    logic               done_o;
    logic               error_o;

    keccak_stream_ctrl #(
        .STATE_W        (STATE_W),
        .LANE_W         (LANE_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) u_dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .start_i             (start_i),
        .din_i               (din_i),
        .in_lanes_i          (in_lanes_i),
        .out_lanes_i         (out_lanes_i),
        .ready_keccak_i      (ready_keccak_i),
        .dout_keccak_i       (dout_keccak_i),
        .dout_valid_keccak_i (dout_valid_keccak_i),
        .start_keccak_o      (start_keccak_o),
        .din_keccak_o        (din_keccak_o),
        .din_valid_keccak_o  (din_valid_keccak_o),
        .last_block_keccak_o (last_block_keccak_o),
        .dout_o              (dout_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .error_o             (error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations of the most recent transaction.
    logic [LANE_W-1:0]  beat_data [NL];
    int                 beats, start_cnt, last_cnt, busy_cycles, din_idle_nz;
    int                 start_t, last_t, done_t, last_valid_t;
    logic               err_at_done, err_at_start, err_early;
    logic               post_busy, post_done, post_err;
    logic [STATE_W-1:0] post_dout;

    function automatic logic [STATE_W-1:0] make_din(input logic [LANE_W-1:0] base);
        logic [STATE_W-1:0] d;
        for (int k = 0; k < NL; k++) d[k*LANE_W +: LANE_W] = base + LANE_W'(k + 1);
        return d;
    endfunction

    // Runs one transaction from a negedge and returns at the negedge of the first IDLE cycle.
    task automatic run_txn(input logic [LANE_W-1:0] base, input int in_l, input int out_l,
                           input int delay, input int n_emit, input int ready_wait,
                           input bit repulse);
        int t_last;
        int emitted;
        bit seen_last;
        bit finished;
        t_last = 0; emitted = 0; seen_last = 0; finished = 0;
        beats = 0; start_cnt = 0; last_cnt = 0; busy_cycles = 0; din_idle_nz = 0;
        start_t = -1; last_t = -1; done_t = -1; last_valid_t = -1;
        err_at_done = 0; err_at_start = 0; err_early = 0;
        din_i = make_din(base);
        in_lanes_i = IDX_W'(in_l);
        out_lanes_i = IDX_W'(out_l);
        start_i = 1'b1;
        ready_keccak_i = (ready_wait == 0);
        dout_valid_keccak_i = 1'b0;
        for (int t = 0; t < 300 && !finished; t++) begin
            @(negedge clk_i);
            if (start_keccak_o) begin
                start_cnt++;
                if (start_t < 0) begin
                    start_t = t;
                    err_at_start = error_o;
                end
                start_i = 1'b0;
            end
            if (din_valid_keccak_o) begin
                if (beats < NL) beat_data[beats] = din_keccak_o;
                beats++;
            end else if (din_keccak_o != '0) begin
                din_idle_nz++;
            end
            if (last_block_keccak_o) begin
                last_cnt++;
                t_last = t;
                last_t = t;
                seen_last = 1;
            end
            if (busy_o) busy_cycles++;
            if (done_o) begin
                finished = 1;
                done_t = t;
                err_at_done = error_o;
            end else if (error_o && start_t >= 0) begin
                err_early = 1;
            end
            // Drive inputs for the edge that ends this cycle.
            if (ready_wait > 0 && t == ready_wait - 1) ready_keccak_i = 1'b1;
            if (repulse && din_valid_keccak_o) start_i = (beats == 4);
            if (din_valid_keccak_o) begin
                dout_valid_keccak_i = 1'b1;
                dout_keccak_i = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (seen_last && t >= t_last + delay && emitted < n_emit) begin
                dout_valid_keccak_i = 1'b1;
                dout_keccak_i = beat_data[emitted];
                emitted++;
                last_valid_t = t;
            end else begin
                dout_valid_keccak_i = 1'b0;
                dout_keccak_i = {32'hDEAD_0000, 32'(t)};
            end
        end
        n_cmp++;
        if (!finished) begin
            n_fail++;
            $display("FAIL txn_done_timeout: done_o never seen in 300 cycles, required 1");
        end
        @(negedge clk_i);
        dout_valid_keccak_i = 1'b0;
        post_busy = busy_o;
        post_done = done_o;
        post_err  = error_o;
        post_dout = dout_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        start_i = 1'b1;
        ready_keccak_i = 1'b1;
        din_i = make_din(64'h1);
        in_lanes_i = '0;
        out_lanes_i = '0;
        dout_valid_keccak_i = 1'b1;
        dout_keccak_i = '1;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (start_keccak_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, want 0", start_keccak_o); end
        n_cmp++; if (din_valid_keccak_o !== 1'b0) begin n_fail++; $display("FAIL reset_din_valid: got %b, want 0", din_valid_keccak_o); end
        n_cmp++; if (din_keccak_o !== '0) begin n_fail++; $display("FAIL reset_din: got %h, want 0", din_keccak_o); end
        n_cmp++; if (last_block_keccak_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b, want 0", last_block_keccak_o); end
        n_cmp++; if (dout_o !== '0) begin n_fail++; $display("FAIL reset_dout: got nonzero, want 0"); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, want 0", done_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b, want 0", error_o); end
        start_i = 1'b0;
        dout_valid_keccak_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, want 0", busy_o); end
    endtask

    // Full 25-in / 25-out transaction; core answers 5 cycles after last-block.
    task automatic test_full_state(input logic [LANE_W-1:0] base, input string tag);
        run_txn(base, 25, 25, 5, 25, 0, 1'b0);
        n_cmp++; if (start_cnt !== 1) begin n_fail++; $display("FAIL %s_start_pulses: got %0d, want 1", tag, start_cnt); end
        n_cmp++; if (start_t !== 0) begin n_fail++; $display("FAIL %s_start_cycle: got %0d, want 0", tag, start_t); end
        n_cmp++; if (beats !== 25) begin n_fail++; $display("FAIL %s_beats: got %0d, want 25", tag, beats); end
        for (int k = 0; k < NL; k++) begin
            n_cmp++;
            if (beat_data[k] !== base + LANE_W'(k + 1)) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got %h, want %h", tag, k, beat_data[k], base + LANE_W'(k + 1));
            end
        end
        n_cmp++; if (last_cnt !== 1) begin n_fail++; $display("FAIL %s_last_pulses: got %0d, want 1", tag, last_cnt); end
        n_cmp++; if (last_t !== 26) begin n_fail++; $display("FAIL %s_last_cycle: got %0d, want 26", tag, last_t); end
        n_cmp++; if (din_idle_nz !== 0) begin n_fail++; $display("FAIL %s_din_idle_zero: got %0d nonzero cycles, want 0", tag, din_idle_nz); end
        n_cmp++; if (busy_cycles !== 57) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d, want 57", tag, busy_cycles); end
        n_cmp++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL %s_error: got %b, want 0", tag, err_at_done); end
        n_cmp++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin n_fail++; $display("FAIL %s_post_idle: busy=%b done=%b, want 0 0", tag, post_busy, post_done); end
        for (int k = 0; k < NL; k++) begin
            n_cmp++;
            if (post_dout[k*LANE_W +: LANE_W] !== base + LANE_W'(k + 1)) begin
                n_fail++;
                $display("FAIL %s_dout%0d: got %h, want %h", tag, k, post_dout[k*LANE_W +: LANE_W], base + LANE_W'(k + 1));
            end
        end
    endtask

    // 17 in / 4 out with the core answering right after last-block: minimum latency.
    task automatic test_partial_lanes();
        logic [LANE_W-1:0] exp;
        run_txn(64'hA5A5_0000_0000_0000, 17, 4, 1, 4, 0, 1'b0);
        n_cmp++; if (beats !== 17) begin n_fail++; $display("FAIL partial_beats: got %0d, want 17", beats); end
        for (int k = 0; k < 17; k++) begin
            n_cmp++;
            if (beat_data[k] !== 64'hA5A5_0000_0000_0000 + LANE_W'(k + 1)) begin
                n_fail++;
                $display("FAIL partial_beat%0d: got %h", k, beat_data[k]);
            end
        end
        n_cmp++; if (busy_cycles !== 24) begin n_fail++; $display("FAIL partial_busy_cycles: got %0d, want 24", busy_cycles); end
        for (int k = 0; k < NL; k++) begin
            exp = (k < 4) ? 64'hA5A5_0000_0000_0000 + LANE_W'(k + 1) : '0;
            n_cmp++;
            if (post_dout[k*LANE_W +: LANE_W] !== exp) begin
                n_fail++;
                $display("FAIL partial_dout%0d: got %h, want %h", k, post_dout[k*LANE_W +: LANE_W], exp);
            end
        end
    endtask

    // in_lanes = 0 and out_lanes = 30 both clamp to 25.
    task automatic test_clamp();
        run_txn(64'h0000_0000_0000_1000, 0, 30, 1, 25, 0, 1'b0);
        n_cmp++; if (beats !== 25) begin n_fail++; $display("FAIL clamp_beats: got %0d, want 25", beats); end
        n_cmp++; if (busy_cycles !== 53) begin n_fail++; $display("FAIL clamp_busy_cycles: got %0d, want 53", busy_cycles); end
        n_cmp++;
        if (post_dout[24*LANE_W +: LANE_W] !== 64'h0000_0000_0000_1019) begin
            n_fail++;
            $display("FAIL clamp_dout24: got %h, want 0000000000001019", post_dout[24*LANE_W +: LANE_W]);
        end
    endtask

    // Core delivers 2 of 4 lanes and goes silent; watchdog of 8 idle cycles ends it.
    task automatic test_timeout();
        logic [LANE_W-1:0] exp;
        run_txn(64'hC3C3_0000_0000_0000, 6, 4, 2, 2, 0, 1'b0);
        n_cmp++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL timeout_error_at_done: got %b, want 1", err_at_done); end
        n_cmp++; if (err_early !== 1'b0) begin n_fail++; $display("FAIL timeout_error_early: got %b, want 0", err_early); end
        n_cmp++; if (done_t - last_valid_t !== 9) begin n_fail++; $display("FAIL timeout_delay: got %0d, want 9 (8 idle cycles)", done_t - last_valid_t); end
        n_cmp++; if (busy_cycles !== 20) begin n_fail++; $display("FAIL timeout_busy_cycles: got %0d, want 20", busy_cycles); end
        n_cmp++; if (post_err !== 1'b1) begin n_fail++; $display("FAIL timeout_error_sticky: got %b, want 1", post_err); end
        for (int k = 0; k < 4; k++) begin
            exp = (k < 2) ? 64'hC3C3_0000_0000_0000 + LANE_W'(k + 1) : '0;
            n_cmp++;
            if (post_dout[k*LANE_W +: LANE_W] !== exp) begin
                n_fail++;
                $display("FAIL timeout_dout%0d: got %h, want %h", k, post_dout[k*LANE_W +: LANE_W], exp);
            end
        end
    endtask

    // Start on the first IDLE cycle after DONE; also clears the sticky error.
    task automatic test_back_to_back();
        run_txn(64'h0000_0000_0000_0200, 2, 2, 1, 2, 0, 1'b0);
        n_cmp++; if (start_t !== 0) begin n_fail++; $display("FAIL b2b_start_cycle: got %0d, want 0", start_t); end
        n_cmp++; if (err_at_start !== 1'b0) begin n_fail++; $display("FAIL b2b_error_cleared: got %b, want 0", err_at_start); end
        n_cmp++; if (post_err !== 1'b0) begin n_fail++; $display("FAIL b2b_error_post: got %b, want 0", post_err); end
        n_cmp++; if (busy_cycles !== 7) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d, want 7", busy_cycles); end
    endtask

    task automatic test_ready_wait();
        run_txn(64'h0000_0000_0000_0300, 3, 3, 1, 3, 10, 1'b0);
        n_cmp++; if (start_cnt !== 1) begin n_fail++; $display("FAIL ready_start_pulses: got %0d, want 1", start_cnt); end
        n_cmp++; if (start_t !== 10) begin n_fail++; $display("FAIL ready_start_cycle: got %0d, want 10", start_t); end
        n_cmp++; if (busy_cycles !== 9) begin n_fail++; $display("FAIL ready_busy_cycles: got %0d, want 9", busy_cycles); end
    endtask

    task automatic test_repulse();
        run_txn(64'h0000_0000_0000_0400, 8, 2, 1, 2, 0, 1'b1);
        n_cmp++; if (start_cnt !== 1) begin n_fail++; $display("FAIL repulse_start_pulses: got %0d, want 1", start_cnt); end
        n_cmp++; if (beats !== 8) begin n_fail++; $display("FAIL repulse_beats: got %0d, want 8", beats); end
        n_cmp++; if (busy_cycles !== 13) begin n_fail++; $display("FAIL repulse_busy_cycles: got %0d, want 13", busy_cycles); end
        n_cmp++;
        if (post_dout[1*LANE_W +: LANE_W] !== 64'h0000_0000_0000_0402) begin
            n_fail++;
            $display("FAIL repulse_dout1: got %h, want 0000000000000402", post_dout[1*LANE_W +: LANE_W]);
        end
    endtask

    task automatic test_reset_mid();
        int t_last;
        bit seen;
        int dones;
        int busies;
        t_last = 0; seen = 0; dones = 0; busies = 0;
        din_i = make_din(64'h7700);
        in_lanes_i = IDX_W'(3);
        out_lanes_i = IDX_W'(3);
        ready_keccak_i = 1'b1;
        start_i = 1'b1;
        dout_valid_keccak_i = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk_i);
            if (start_keccak_o) start_i = 1'b0;
            if (last_block_keccak_o) begin
                seen = 1;
                t_last = t;
            end
            dout_valid_keccak_i = seen && (t == t_last + 1);
            dout_keccak_i = 64'h1234_5678;
            if (seen && t == t_last + 3) break;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach_collect: no last_block seen, want 1"); end
        n_cmp++; if (dout_o[LANE_W-1:0] !== 64'h1234_5678) begin n_fail++; $display("FAIL rstmid_lane0_before: got %h, want 12345678", dout_o[LANE_W-1:0]); end
        dout_valid_keccak_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (dout_o !== '0) begin n_fail++; $display("FAIL rstmid_dout: got nonzero, want 0"); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b, want 0", done_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_error: got %b, want 0", error_o); end
        n_cmp++;
        if ({start_keccak_o, din_valid_keccak_o, last_block_keccak_o} !== 3'b000 || din_keccak_o !== '0) begin
            n_fail++;
            $display("FAIL rstmid_core_if: start=%b valid=%b last=%b din=%h, want all 0",
                     start_keccak_o, din_valid_keccak_o, last_block_keccak_o, din_keccak_o);
        end
        rst_ni = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk_i);
            if (done_o) dones++;
            if (busy_o) busies++;
        end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses, want 0", dones); end
        n_cmp++; if (busies !== 0) begin n_fail++; $display("FAIL rstmid_stays_idle: got %0d busy cycles, want 0", busies); end
    endtask

    initial begin
        test_reset();
        test_full_state(64'h0, "full");
        test_partial_lanes();
        test_clamp();
        test_timeout();
        test_back_to_back();
        test_ready_wait();
        test_repulse();
        test_reset_mid();
        test_full_state(64'h5500_0000_0000_0000, "after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
